// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and writeback.
//   Consumes exec_mem_* registers. Issues loads/stores on a req/ack data bus,
//   positions store data on byte lanes, extracts and extends load data, and
//   produces mem_wb_* registers.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   exec_mem_*            upstream pipeline register outputs (held while mem_stall)
//   dbus_req/we/addr/be/wdata  registered bus request, stable until dbus_ack
//   dbus_ack, dbus_rdata  bus completion and read data
//   mem_stall             combinational upstream hold
//   mem_wb_*              registered writeback-stage inputs; mem_wb_fault pulses
module mem_stage #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exec_mem_writeback,
  input  logic        exec_mem_link,
  input  logic        exec_mem_mem_w,
  input  logic        exec_mem_mem_r,
  input  logic        exec_mem_mem_rdu,
  input  logic        exec_mem_mem_byte,
  input  logic        exec_mem_mem_hwrd,
  input  logic        exec_mem_mem_wrd,
  input  logic [5:0]  exec_mem_rd,
  input  logic [31:0] exec_mem_alu_result,
  input  logic [31:0] exec_mem_mem_wdata,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        mem_stall,
  output logic        mem_wb_writeback,
  output logic        mem_wb_link,
  output logic [5:0]  mem_wb_rd,
  output logic [31:0] mem_wb_result,
  output logic        mem_wb_fault
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  localparam bit         TO_EN   = (ACK_TIMEOUT != 0);
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  logic [0:0] state;
  logic [7:0] cnt;

  // Size decode: anything not cleanly byte or halfword is handled as a word.
  logic       op, sz_b, sz_h, aligned, timeout_hit;
  logic [1:0] off;
  logic [3:0] be_c;
  logic [3:0][7:0] st_lanes, ld_lanes;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;

  assign op   = exec_mem_mem_r | exec_mem_mem_w;
  assign off  = exec_mem_alu_result[1:0];
  assign sz_b = exec_mem_mem_byte & ~exec_mem_mem_hwrd & ~exec_mem_mem_wrd;
  assign sz_h = exec_mem_mem_hwrd & ~exec_mem_mem_byte & ~exec_mem_mem_wrd;

  assign aligned = sz_b | (sz_h & ~off[0]) | (~sz_b & ~sz_h & (off == 2'd0));

  assign be_c = sz_b ? (4'b0001 << off) :
                sz_h ? (4'b0011 << off) : 4'b1111;

  // Store lanes: byte replicated x4, halfword x2, word as is.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign st_lanes[i] = sz_b ? exec_mem_mem_wdata[7:0] :
                         sz_h ? exec_mem_mem_wdata[8*(i%2) +: 8] :
                                exec_mem_mem_wdata[8*i +: 8];
  end

  assign ld_lanes = dbus_rdata;
  assign ld_h     = off[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];

  always_comb begin
    ld_ext = dbus_rdata;
    if (sz_b)
      ld_ext = {{24{ld_lanes[off][7] & ~exec_mem_mem_rdu}}, ld_lanes[off]};
    else if (sz_h)
      ld_ext = {{16{ld_h[15] & ~exec_mem_mem_rdu}}, ld_h};
  end

  assign timeout_hit = TO_EN && (cnt == TO_LAST);

  // In REQ the stall drops on the ack or timeout cycle so the next upstream
  // instruction is accepted on the same edge that retires this access.
  assign mem_stall = (state == S_IDLE) ? (op & aligned) : (~dbus_ack & ~timeout_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      cnt              <= '0;
      dbus_req         <= 1'b0;
      dbus_we          <= 1'b0;
      dbus_addr        <= '0;
      dbus_be          <= '0;
      dbus_wdata       <= '0;
      mem_wb_writeback <= 1'b0;
      mem_wb_link      <= 1'b0;
      mem_wb_rd        <= '0;
      mem_wb_result    <= '0;
      mem_wb_fault     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op && aligned) begin
            state            <= S_REQ;
            cnt              <= '0;
            dbus_req         <= 1'b1;
            dbus_we          <= exec_mem_mem_w;
            dbus_addr        <= {exec_mem_alu_result[31:2], 2'b00};
            dbus_be          <= be_c;
            dbus_wdata       <= st_lanes;
            mem_wb_writeback <= 1'b0;
            mem_wb_fault     <= 1'b0;
          end else begin
            // Non-op passes through; misaligned op becomes a faulting bubble.
            mem_wb_writeback <= exec_mem_writeback & ~op;
            mem_wb_link      <= exec_mem_link;
            mem_wb_rd        <= exec_mem_rd;
            mem_wb_result    <= exec_mem_alu_result;
            mem_wb_fault     <= op;
          end
        end
        default: begin
          if (dbus_ack) begin
            state            <= S_IDLE;
            dbus_req         <= 1'b0;
            mem_wb_writeback <= exec_mem_writeback;
            mem_wb_link      <= exec_mem_link;
            mem_wb_rd        <= exec_mem_rd;
            mem_wb_result    <= exec_mem_mem_w ? exec_mem_alu_result : ld_ext;
            mem_wb_fault     <= 1'b0;
          end else if (timeout_hit) begin
            state            <= S_IDLE;
            dbus_req         <= 1'b0;
            mem_wb_writeback <= 1'b0;
            mem_wb_link      <= exec_mem_link;
            mem_wb_rd        <= exec_mem_rd;
            mem_wb_result    <= exec_mem_alu_result;
            mem_wb_fault     <= 1'b1;
          end else begin
            cnt              <= cnt + 8'd1;
            mem_wb_writeback <= 1'b0;
            mem_wb_fault     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        writeback, link, mem_w, mem_r, rdu, sb, sh, sw;
  logic [5:0]  rd;
  logic [31:0] alu, wdata;
  logic        dbus_req, dbus_we, dbus_ack;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;
  logic        mem_stall, wb_writeback, wb_link, wb_fault;
  logic [5:0]  wb_rd;
  logic [31:0] wb_result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .exec_mem_writeback(writeback), .exec_mem_link(link),
    .exec_mem_mem_w(mem_w), .exec_mem_mem_r(mem_r), .exec_mem_mem_rdu(rdu),
    .exec_mem_mem_byte(sb), .exec_mem_mem_hwrd(sh), .exec_mem_mem_wrd(sw),
    .exec_mem_rd(rd), .exec_mem_alu_result(alu), .exec_mem_mem_wdata(wdata),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .mem_stall(mem_stall),
    .mem_wb_writeback(wb_writeback), .mem_wb_link(wb_link), .mem_wb_rd(wb_rd),
    .mem_wb_result(wb_result), .mem_wb_fault(wb_fault)
  );

  task automatic clear_inputs();
    {writeback, link, mem_w, mem_r, rdu, sb, sh, sw} = '0;
    rd = '0; alu = '0; wdata = '0; dbus_ack = 1'b0; dbus_rdata = '0;
  endtask

  task automatic run_instr(input logic w, r, u, b, h, wd, wbk, lnk,
                           input logic [5:0] d, input logic [31:0] a, wdat, rdat,
                           input int delay);
    logic op, al, done;
    int n, off;
    logic [31:0] mask, v, e_res, e_wd;
    logic [3:0] e_be;
    mem_w = w; mem_r = r; rdu = u; sb = b; sh = h; sw = wd;
    writeback = wbk; link = lnk; rd = d; alu = a; wdata = wdat;
    op  = w | r;
    n   = (b && !h && !wd) ? 1 : (h && !b && !wd) ? 2 : 4;
    off = int'(a[1:0]);
    al  = (off % n) == 0;
    e_be = 4'(((1 << n) - 1) << off);
    e_wd = (n == 1) ? {24'd0, wdat[7:0]} * 32'h01010101 :
           (n == 2) ? {16'd0, wdat[15:0]} * 32'h00010001 : wdat;
    mask = (n == 4) ? 32'hFFFFFFFF : (32'd1 << (8 * n)) - 32'd1;
    v = (rdat >> (8 * off)) & mask;
    if (!u && n < 4 && v[8*n-1]) v = v | ~mask;
    e_res = w ? a : v;
    #1;
    tests++; if (mem_stall !== (op && al)) begin
      fails++;
      $display("FAIL stall_issue: got %b exp %b addr=%h", mem_stall, op && al, a);
    end
    if (!(op && al)) begin
      @(posedge clk); #1;
      tests++; if ({dbus_req, wb_writeback, wb_fault, wb_link, wb_rd, wb_result} !==
                   {1'b0, wbk & ~op, op, lnk, d, a}) begin
        fails++;
        $display("FAIL pass_or_misalign: got req=%b wb=%b f=%b l=%b rd=%0d res=%h exp wb=%b f=%b rd=%0d res=%h",
                 dbus_req, wb_writeback, wb_fault, wb_link, wb_rd, wb_result, wbk & ~op, op, d, a);
      end
      return;
    end
    @(posedge clk); #1;
    tests++; if ({dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, wb_writeback, wb_fault} !==
                 {1'b1, w, a & 32'hFFFFFFFC, e_be, e_wd, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL bus_issue: got req=%b we=%b addr=%h be=%b wd=%h wb=%b f=%b exp we=%b addr=%h be=%b wd=%h",
               dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, wb_writeback, wb_fault,
               w, a & 32'hFFFFFFFC, e_be, e_wd);
    end
    done = 1'b0;
    for (int k = 0; k < 8 && !done; k++) begin
      if (k == delay) begin
        dbus_ack = 1'b1; dbus_rdata = rdat; #1;
        tests++; if (mem_stall !== 1'b0) begin
          fails++;
          $display("FAIL stall_ack: got %b exp 0", mem_stall);
        end
        @(posedge clk); #1;
        dbus_ack = 1'b0; dbus_rdata = $urandom;
        tests++; if ({dbus_req, wb_writeback, wb_link, wb_rd, wb_result, wb_fault} !==
                     {1'b0, wbk, lnk, d, e_res, 1'b0}) begin
          fails++;
          $display("FAIL complete: got req=%b wb=%b rd=%0d res=%h f=%b exp wb=%b rd=%0d res=%h",
                   dbus_req, wb_writeback, wb_rd, wb_result, wb_fault, wbk, d, e_res);
        end
        done = 1'b1;
      end else if (k == TO - 1) begin
        #1;
        tests++; if (mem_stall !== 1'b0) begin
          fails++;
          $display("FAIL stall_timeout: got %b exp 0", mem_stall);
        end
        @(posedge clk); #1;
        tests++; if ({dbus_req, wb_fault, wb_writeback} !== 3'b010) begin
          fails++;
          $display("FAIL timeout: got req=%b f=%b wb=%b exp req=0 f=1 wb=0",
                   dbus_req, wb_fault, wb_writeback);
        end
        done = 1'b1;
      end else begin
        dbus_rdata = $urandom; #1;
        tests++; if ({mem_stall, dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, wb_writeback} !==
                     {1'b1, 1'b1, w, a & 32'hFFFFFFFC, e_be, e_wd, 1'b0}) begin
          fails++;
          $display("FAIL hold_k%0d: got stall=%b req=%b addr=%h be=%b wd=%h wb=%b", k,
                   mem_stall, dbus_req, dbus_addr, dbus_be, dbus_wdata, wb_writeback);
        end
        @(posedge clk); #1;
      end
    end
    tests++; if (!done) begin
      fails++;
      $display("FAIL access_bound: got no completion exp done");
    end
  endtask

  task automatic test_reset();
    clear_inputs(); rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    tests++; if ({dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, mem_stall,
                 wb_writeback, wb_link, wb_rd, wb_result, wb_fault} !== '0) begin
      fails++;
      $display("FAIL reset_state: got req=%b addr=%h be=%b wd=%h wb=%b rd=%0d res=%h f=%b exp all 0",
               dbus_req, dbus_addr, dbus_be, dbus_wdata, wb_writeback, wb_rd, wb_result, wb_fault);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu_pass();
    run_instr(0,0,0,0,0,0, 1,0, 6'd5, 32'h1234, 0, 0, 0);
  endtask

  task automatic test_byte_load();
    run_instr(0,1,0,1,0,0, 1,0, 6'd7, 32'h103, 0, 32'h80AABBCC, 0);
    run_instr(0,1,1,1,0,0, 1,0, 6'd8, 32'h103, 0, 32'h80AABBCC, 0);
  endtask

  task automatic test_hwrd_store();
    run_instr(1,0,0,0,1,0, 0,0, 6'd0, 32'h202, 32'h0000BEEF, 0, 3);
  endtask

  task automatic test_misaligned();
    run_instr(0,1,0,0,0,1, 1,0, 6'd9, 32'h301, 0, 0, 0);
    run_instr(0,0,0,0,0,0, 1,1, 6'd3, 32'h55, 0, 0, 0);
  endtask

  task automatic test_timeout();
    run_instr(0,1,0,0,0,1, 1,0, 6'd4, 32'h400, 0, 0, 100);
    run_instr(0,0,0,0,0,0, 1,0, 6'd2, 32'h77, 0, 0, 0);
  endtask

  task automatic test_reset_mid_access();
    run_instr(0,0,0,0,0,0, 0,0, 6'd0, 32'h0, 0, 0, 0);
    mem_r = 1'b1; sw = 1'b1; writeback = 1'b1; rd = 6'd11; alu = 32'h500;
    @(posedge clk); #1;
    tests++; if (dbus_req !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_setup: got req=%b exp 1", dbus_req);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    clear_inputs(); rst = 1'b0;
    tests++; if ({dbus_req, dbus_addr, dbus_be, wb_writeback, wb_rd, wb_result, wb_fault} !== '0) begin
      fails++;
      $display("FAIL rst_mid: got req=%b addr=%h wb=%b rd=%0d res=%h exp all 0",
               dbus_req, dbus_addr, wb_writeback, wb_rd, wb_result);
    end
    dbus_ack = 1'b1; dbus_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    tests++; if ({dbus_req, wb_writeback, wb_rd, wb_result, wb_fault, mem_stall} !== '0) begin
      fails++;
      $display("FAIL late_ack: got req=%b wb=%b res=%h f=%b stall=%b exp all 0",
               dbus_req, wb_writeback, wb_result, wb_fault, mem_stall);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 200; i++) begin
      logic [2:0] sz;
      logic w, r;
      sz = 3'($urandom);
      if ($urandom_range(0, 3) == 0) sz = 3'b001 << $urandom_range(0, 2);
      w = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 1) == 0);
      run_instr(w, r, 1'($urandom), sz[0], sz[1], sz[2], 1'($urandom), 1'($urandom),
                6'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 5));
    end
  endtask

  initial begin
    clear_inputs(); rst = 1'b1;
    test_reset();
    test_alu_pass();
    test_byte_load();
    test_hwrd_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage. Sits directly downstream of execute and consumes its exec_mem_* pipeline register outputs.
- Performs loads and stores over a variable-latency req/ack data bus and handles byte-lane alignment and load sign/zero extension.
- Stalls upstream while an access is in flight.
- Produces mem_wb_* pipeline registers for writeback.

Parameters:
ACK_TIMEOUT, 255, max cycles dbus_req may wait for dbus_ack before the access is aborted as a fault (8-bit counter; 0 disables timeout)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
exec_mem_writeback  in  1  instruction writes rd
exec_mem_link  in  1  link flag, passed through
exec_mem_mem_w / exec_mem_mem_r  in  1 each  store / load
exec_mem_mem_rdu  in  1  unsigned load
exec_mem_mem_byte / exec_mem_mem_hwrd / exec_mem_mem_wrd  in  1 each  access size (one-hot when mem_r|mem_w)
exec_mem_rd  in  6  destination register
exec_mem_alu_result  in  32  address for mem ops, else result
exec_mem_mem_wdata  in  32  store data (low bits significant)
dbus_req  out  1  bus request
dbus_we  out  1  1=write
dbus_addr  out  32  word-aligned address (addr[1:0]=0)
dbus_be  out  4  byte enables
dbus_wdata  out  32  lane-positioned store data
dbus_ack  in  1  request accepted/completed this cycle
dbus_rdata  in  32  read data, valid when dbus_ack=1
mem_stall  out  1  combinational; upstream holds exec_mem_* stable while high
mem_wb_writeback  out  1  registered
mem_wb_link  out  1  registered
mem_wb_rd  out  6  registered
mem_wb_result  out  32  registered: load data or alu result
mem_wb_fault  out  1  registered one-cycle pulse: misaligned access or bus timeout

Behaviour:
- Reset: state=IDLE, timeout counter=0. dbus_req=0, dbus_we=0, dbus_addr=0, dbus_be=0, dbus_wdata=0. All mem_wb_* = 0.
- Reset mid-access drops dbus_req next cycle. A late dbus_ack arriving in IDLE is ignored.
- Let op = exec_mem_mem_r | exec_mem_mem_w; off = exec_mem_alu_result[1:0].
- Alignment:
  - byte: always aligned.
  - hwrd: aligned when off[0]=0.
  - wrd: aligned when off=0.
- Byte enables:
  - byte: 4'b0001<<off
  - hwrd: 4'b0011<<off
  - wrd: 4'b1111
- Store data:
  - byte: wdata[7:0] replicated x4
  - hwrd: wdata[15:0] replicated x2
  - wrd: as is
- FSM states: IDLE, REQ.
- IDLE, non-op:
  - mem_wb_* <= pass-through; mem_wb_result <= exec_mem_alu_result; fault <= 0.
  - mem_stall=0. Latency 1 cycle.
- IDLE, op misaligned:
  - No bus access, mem_stall=0.
  - mem_wb_fault <= 1, mem_wb_writeback <= 0, rd/result passed through.
- IDLE, op aligned:
  - mem_stall=1. Next state REQ.
  - dbus_req/we/addr/be/wdata registered from current inputs.
  - mem_wb_writeback <= 0 (bubble), fault <= 0. Counter cleared.
- REQ:
  - dbus_* held stable until ack.
  - mem_stall = ~dbus_ack.
  - Counter increments each cycle without ack.
- REQ with dbus_ack=1:
  - dbus_req <= 0, state <= IDLE.
  - mem_wb_writeback/link/rd <= exec_mem_* (still held, since stall was high).
  - Load: select lane by off. byte=rdata[8*off+:8], hwrd=rdata[16*off[1]+:16]. Sign-extend unless rdu; wrd as is. Result goes to mem_wb_result.
  - Store: mem_wb_result <= exec_mem_alu_result.
  - The next upstream instruction is accepted at that same edge, so back-to-back ops re-enter IDLE decision.
- REQ timeout (ACK_TIMEOUT≠0 and counter==ACK_TIMEOUT-1 with no ack):
  - dbus_req <= 0, IDLE.
  - mem_wb_fault <= 1, mem_wb_writeback <= 0. mem_stall=0 that cycle.
- Ack and timeout in the same cycle: ack wins.
- Minimum aligned access = 2 cycles (present cycle + ack cycle).
- Simultaneous mem_r and mem_w: treated as store.
- Zero or non-one-hot size with op: treated as wrd.

Test Plan:
- Non-mem ALU op, alu_result=0x1234, rd=5, writeback=1 -> next cycle mem_wb_result=0x1234, rd=5, writeback=1, mem_stall never high.
- Signed byte load addr 0x103, ack in 1st REQ cycle, rdata=0x80AABBCC -> dbus_be=4'b1000, dbus_addr=0x100, mem_wb_result=0xFFFFFF80. Repeat with rdu=1 -> 0x00000080.
- Halfword store addr 0x202, wdata=0x0000BEEF, ack delayed 3 cycles -> dbus_be=4'b1100, dbus_wdata=0xBEEFBEEF, dbus_we=1. mem_stall high 4 cycles, bus signals stable until ack, mem_wb_writeback=0.
- Word load addr 0x301 -> no dbus_req, mem_wb_fault pulses 1 cycle, mem_wb_writeback=0.
- ACK_TIMEOUT=4, ack never arrives -> dbus_req high exactly 4 cycles then drops. mem_wb_fault=1 for one cycle, stall releases.
- rst asserted during REQ, then dbus_ack=1 after reset -> all outputs 0 after reset edge, ack ignored, no mem_wb update.
